// File: rtl/loopback_frame_emulator_if.sv
// Byte-wide valid/ready stream used for both the MOSI (inbound) and MISO (outbound) sides.
interface loopback_frame_emulator_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  // Producer side of the stream.
  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  // Consumer side of the stream.
  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/loopback_frame_emulator.sv
// Loopback frame emulator: decodes command bytes from the MOSI stream and emits
// framed responses (header, length, payload, XOR checksum) on the MISO stream.
// Payload is either a persistent sequence counter (GEN) or echoed input (ECHO).
module loopback_frame_emulator #(
  parameter logic [7:0] CMD_GEN   = 8'h20,
  parameter logic [7:0] CMD_ECHO  = 8'h40,
  parameter logic [7:0] FRAME_HDR = 8'hA5
) (
  input  logic                           clk_core,
  input  logic                           clk_core_res,
  input  logic                           enable,
  loopback_frame_emulator_if.slave       s_axis,
  loopback_frame_emulator_if.master      m_axis,
  output logic                           busy,
  output logic [15:0]                    frame_count,
  output logic [7:0]                     err_count
);

  // Each non-idle state names the byte currently held (or about to be held) in the
  // output register; the state advances when that byte is handed off downstream.
  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHdr,
    StLenOut,
    StPayload,
    StCsum
  } state_e;

  state_e      state_q, state_d;
  logic        echo_q, echo_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;
  // Low while in reset and until the first edge after release, so command
  // acceptance only starts one clock after reset is removed.
  logic        run_q;

  logic        s_ready;
  logic        s_fire;
  logic        drain;
  logic        can_load;
  logic        more_to_load;

  // Run flag: rises on the first clock edge after reset release.
  always_ff @(posedge clk_core or posedge clk_core_res) begin
    if (clk_core_res) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_core or posedge clk_core_res) begin
    if (clk_core_res) begin
      state_q       <= StIdle;
      echo_q        <= 1'b0;
      len_q         <= 8'h00;
      rem_q         <= 9'd0;
      seq_q         <= 8'h00;
      csum_q        <= 8'h00;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      frame_count_q <= 16'h0000;
      err_count_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      echo_q        <= echo_d;
      len_q         <= len_d;
      rem_q         <= rem_d;
      seq_q         <= seq_d;
      csum_q        <= csum_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // Next-state, input acceptance and output-register loading.
  always_comb begin
    state_d       = state_q;
    echo_d        = echo_q;
    len_d         = len_q;
    rem_d         = rem_q;
    seq_d         = seq_q;
    csum_d        = csum_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    s_ready       = 1'b0;

    drain    = out_valid_q & m_axis.tready;
    can_load = ~out_valid_q | m_axis.tready;
    // Payload bytes not yet placed in the output register.
    more_to_load = (rem_q - 9'(out_valid_q)) != 9'd0;

    case (state_q)
      StIdle: begin
        s_ready = enable & run_q;
        if (s_ready && s_axis.tvalid) begin
          if (s_axis.tdata == CMD_GEN) begin
            echo_d  = 1'b0;
            state_d = StLen;
          end else if (s_axis.tdata == CMD_ECHO) begin
            echo_d  = 1'b1;
            state_d = StLen;
          end else if (s_axis.tdata != 8'h00 && s_axis.tdata != 8'hFF) begin
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        end
      end

      StLen: begin
        s_ready = 1'b1;
        if (s_axis.tvalid) begin
          len_d       = s_axis.tdata;
          rem_d       = (s_axis.tdata == 8'h00) ? 9'd256 : {1'b0, s_axis.tdata};
          csum_d      = 8'h00;
          // Register is empty here, so the header goes out on the very next cycle.
          out_data_d  = FRAME_HDR;
          out_valid_d = 1'b1;
          state_d     = StHdr;
        end
      end

      StHdr: begin
        if (drain) begin
          out_data_d = len_q;
          state_d    = StLenOut;
        end
      end

      StLenOut: begin
        if (drain) begin
          state_d = StPayload;
          if (!echo_q) begin
            // Preload the first generated byte to avoid a bubble after the length.
            out_data_d = seq_q;
            seq_d      = seq_q + 8'd1;
            csum_d     = csum_q ^ seq_q;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end

      StPayload: begin
        if (drain) begin
          rem_d = rem_q - 9'd1;
        end
        if (drain && rem_q == 9'd1) begin
          // Last payload byte leaves now; every payload byte is already in csum_q.
          out_data_d = csum_q;
          state_d    = StCsum;
        end else if (can_load && more_to_load) begin
          if (!echo_q) begin
            out_data_d  = seq_q;
            out_valid_d = 1'b1;
            seq_d       = seq_q + 8'd1;
            csum_d      = csum_q ^ seq_q;
          end else begin
            s_ready = 1'b1;
            if (s_axis.tvalid) begin
              out_data_d  = s_axis.tdata;
              out_valid_d = 1'b1;
              csum_d      = csum_q ^ s_axis.tdata;
            end else if (drain) begin
              out_valid_d = 1'b0;
            end
          end
        end else if (drain) begin
          out_valid_d = 1'b0;
        end
      end

      StCsum: begin
        if (drain) begin
          out_valid_d   = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign s_fire        = s_ready & s_axis.tvalid;
  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tvalid = out_valid_q;
  assign busy          = (state_q != StIdle);
  assign frame_count   = frame_count_q;
  assign err_count     = err_count_q;

  // Handshake indicator kept for debug visibility; acceptance is decoded per state.
  logic s_fire_unused;
  assign s_fire_unused = s_fire;

endmodule

// File: tb/tb_loopback_frame_emulator.sv
// Randomized self-checking bench: a stream-level reference model predicts the
// emitted bytes and counters for each injected MOSI byte stream.
module tb_loopback_frame_emulator;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  loopback_frame_emulator_if s_if ();
  loopback_frame_emulator_if m_if ();

  loopback_frame_emulator dut (
    .clk_core     (clk),
    .clk_core_res (rst),
    .enable       (enable),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .busy         (busy),
    .frame_count  (frame_count),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Reference model state.
  logic [7:0]  m_seq;
  logic [15:0] m_fc;
  logic [7:0]  m_ec;

  int unsigned vld_pct;
  int unsigned rdy_pct;
  int unsigned en_pct;
  bit          toggle;
  bit          hold_pend;
  logic [7:0]  hold_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream-level model: parse commands and append the expected response bytes.
  task automatic model(input logic [7:0] s[$]);
    int         i;
    int         n;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] x;
    i = 0;
    while (i < s.size()) begin
      b = s[i];
      i++;
      if (b == 8'h20 || b == 8'h40) begin
        n = (s[i] == 8'h00) ? 256 : int'(s[i]);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s[i]);
        i++;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
          if (b == 8'h20) begin
            p = m_seq;
            m_seq = m_seq + 8'd1;
          end else begin
            p = s[i];
            i++;
          end
          x = x ^ p;
          exp_q.push_back(p);
        end
        exp_q.push_back(x);
        m_fc = m_fc + 16'd1;
      end else if (b != 8'h00 && b != 8'hFF) begin
        if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      end
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, commit at posedge.
  task automatic cycle();
    bit         s_fire;
    bit         m_fire;
    logic [7:0] m_data;
    @(negedge clk);
    if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      s_if.tdata  = src_q[0];
      s_if.tvalid = 1'b1;
    end else begin
      s_if.tdata  = 8'($urandom);
      s_if.tvalid = 1'b0;
    end
    if (toggle) m_if.tready = ~m_if.tready;
    else m_if.tready = ($urandom_range(99) < rdy_pct);
    enable = ($urandom_range(99) < en_pct);
    #1;
    if (hold_pend) begin
      check_eq("stall_valid", 32'(m_if.tvalid), 32'd1);
      check_eq("stall_data", 32'(m_if.tdata), 32'(hold_data));
    end
    s_fire    = s_if.tvalid & s_if.tready;
    m_fire    = m_if.tvalid & m_if.tready;
    m_data    = m_if.tdata;
    hold_pend = m_if.tvalid & ~m_if.tready;
    hold_data = m_if.tdata;
    @(posedge clk);
    if (s_fire) void'(src_q.pop_front());
    if (m_fire) got_q.push_back(m_data);
  endtask

  task automatic run_stream(input string tag, input logic [7:0] s[$]);
    int  cyc;
    int  n;
    bit  done;
    got_q.delete();
    exp_q.delete();
    model(s);
    foreach (s[i]) src_q.push_back(s[i]);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 30000) begin
      cycle();
      cyc++;
      #1;
      done = (src_q.size() == 0) && !busy && !m_if.tvalid;
    end
    if (!done) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check_eq({tag, "_frame_count"}, 32'(frame_count), 32'(m_fc));
    check_eq({tag, "_err_count"}, 32'(err_count), 32'(m_ec));
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == 8'h20 || b == 8'h40 || b == 8'h00 || b == 8'hFF) b = 8'($urandom);
    return b;
  endfunction

  initial begin
    logic [7:0] s[$];
    int         n;
    int         cyc;
    n_vec = 0;
    n_err = 0;
    m_seq = 8'h00;
    m_fc  = 16'h0000;
    m_ec  = 8'h00;
    vld_pct = 100;
    rdy_pct = 100;
    en_pct  = 100;
    toggle  = 1'b0;
    hold_pend = 1'b0;
    hold_data = 8'h00;
    rst = 1'b1;
    enable = 1'b1;
    s_if.tdata = 8'h00;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("rst_m_tdata", 32'(m_if.tdata), 32'h00);
    check_eq("rst_s_tready", 32'(s_if.tready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_s_tready_pre", 32'(s_if.tready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rel_s_tready_post", 32'(s_if.tready), 32'd1);

    // Basic GEN frame, then a 256-byte GEN frame wrapping the sequence.
    s = '{8'h20, 8'h03};
    run_stream("gen_basic", s);
    s = '{8'h20, 8'h00};
    run_stream("gen_256", s);

    // ECHO with alternating downstream ready.
    toggle = 1'b1;
    m_if.tready = 1'b1;
    s = '{8'h40, 8'h02, 8'h5A, 8'hC3};
    run_stream("echo_bp", s);
    toggle = 1'b0;

    // Filtered and unknown bytes ahead of a frame.
    s = '{8'h00, 8'hFF, 8'h7E, 8'h20, 8'h01};
    run_stream("filter", s);

    // Reset in the middle of a payload.
    got_q.delete();
    src_q.delete();
    src_q.push_back(8'h20);
    src_q.push_back(8'h10);
    cyc = 0;
    while (got_q.size() < 5 && cyc < 200) begin
      cycle();
      cyc++;
    end
    if (got_q.size() < 5) check_eq("midrst_reach_payload", 32'(got_q.size()), 32'd5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_frame_count", 32'(frame_count), 32'd0);
    check_eq("midrst_err_count", 32'(err_count), 32'd0);
    check_eq("midrst_s_tready", 32'(s_if.tready), 32'd0);
    hold_pend = 1'b0;
    src_q.delete();
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_seq = 8'h00;
    m_fc  = 16'h0000;
    m_ec  = 8'h00;
    got_q.delete();
    repeat (5) cycle();
    check_eq("midrst_no_emit", 32'(got_q.size()), 32'd0);
    s = '{8'h20, 8'h01};
    run_stream("post_rst", s);

    // Randomized mixes of GEN/ECHO frames, junk, stalls and enable gaps.
    for (int r = 0; r < 6; r++) begin
      vld_pct = $urandom_range(100, 50);
      rdy_pct = $urandom_range(100, 30);
      en_pct  = $urandom_range(100, 70);
      s.delete();
      for (int f = 0; f < 8; f++) begin
        n = $urandom_range(2);
        for (int j = 0; j < n; j++) begin
          case ($urandom_range(3))
            0: s.push_back(8'h00);
            1: s.push_back(8'hFF);
            default: s.push_back(junk_byte());
          endcase
        end
        n = ($urandom_range(9) == 0) ? 256 : int'($urandom_range(24, 1));
        if ($urandom_range(1) == 0) begin
          s.push_back(8'h20);
          s.push_back(8'(n));
        end else begin
          s.push_back(8'h40);
          s.push_back(8'(n));
          for (int j = 0; j < n; j++) s.push_back(8'($urandom));
        end
      end
      run_stream("random", s);
    end

    // err_count saturation.
    vld_pct = 100;
    rdy_pct = 100;
    en_pct  = 100;
    s.delete();
    for (int j = 0; j < 300; j++) s.push_back(junk_byte());
    run_stream("saturate", s);
    check_eq("saturate_ff", 32'(err_count), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/loopback_frame_emulator.md
LOOPBACK_FRAME_EMULATOR -- requirements
Module: loopback_frame_emulator

Interface
REQ-001 Parameter CMD_GEN, default 8'h20, command byte requesting a generated frame.
REQ-002 Parameter CMD_ECHO, default 8'h40, command byte requesting an echo frame.
REQ-003 Parameter FRAME_HDR, default 8'hA5, first byte of every emitted frame.
REQ-004 clk_core  in  1  sole clock; all logic on rising edge.
REQ-005 clk_core_res  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  allows new command acceptance.
REQ-007 s_axis_tdata  in  8  MOSI byte from the loopback MOSI FIFO.
REQ-008 s_axis_tvalid  in  1  MOSI byte valid.
REQ-009 s_axis_tready  out  1  MOSI byte accepted when high with tvalid.
REQ-010 m_axis_tdata  out  8  response byte toward the MISO FIFO.
REQ-011 m_axis_tvalid  out  1  response byte valid.
REQ-012 m_axis_tready  in  1  MISO FIFO can accept.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 frame_count  out  16  completed frames, wraps 16'hFFFF->0.
REQ-015 err_count  out  8  discarded unknown command bytes, saturates at 8'hFF.

Function
REQ-016 Transfer on an interface only when tvalid and tready are both high on a clock edge.
REQ-017 m_axis_tdata and m_axis_tvalid are registered, and m_axis_tdata is held stable while tvalid=1 and tready=0.
REQ-018 States are IDLE, LEN, HDR, LENOUT, PAYLOAD and CSUM.
REQ-019 IDLE: s_axis_tready=enable.
  - Accepted 8'h00 and 8'hFF are dropped silently.
  - CMD_GEN or CMD_ECHO latches the mode and moves to LEN.
  - Any other byte increments err_count and stays in IDLE.
REQ-020 LEN: s_axis_tready=1; the accepted byte sets N, with 8'h00 meaning 256; then move to HDR.
REQ-021 HDR emits FRAME_HDR; LENOUT emits the received length byte unchanged; each state advances on output handshake.
REQ-022 PAYLOAD emits N bytes.
  - GEN mode: bytes come from an 8-bit sequence counter, reset value 0, incremented per emitted payload byte, persisting across frames and wrapping 8'hFF->8'h00.
  - ECHO mode: each input byte is passed through, and s_axis_tready is high only while the output register is empty or being drained in that cycle, so no byte is lost or duplicated.
REQ-023 CSUM emits the XOR of all N payload bytes; on handshake, frame_count increments and the FSM returns to IDLE.
REQ-024 The 9-bit remaining-byte counter is loaded with N, decrements per emitted payload byte, and leaves PAYLOAD after the byte emitted at count 1.
REQ-025 s_axis_tready=0 in HDR, LENOUT, CSUM, and in PAYLOAD when in GEN mode.
REQ-026 Output stall of any length in any state suspends progress only; no state, counter or data changes.
REQ-027 enable deasserted mid-frame does not abort the frame; it only blocks acceptance in IDLE.
REQ-028 Upstream starvation in ECHO PAYLOAD holds the state with m_axis_tvalid=0 once the register drains.
REQ-029 Minimum latency: the HDR byte is valid on the cycle after the length byte is accepted.
REQ-030 Throughput: one byte per cycle when m_axis_tready=1 (GEN) or when tvalid and tready are continuous (ECHO).

Reset
REQ-031 While clk_core_res=1:
  - state is IDLE;
  - m_axis_tvalid=0, m_axis_tdata=8'h00, s_axis_tready=0, busy=0;
  - frame_count=0, err_count=0, sequence counter=0, checksum=0.
REQ-032 Reset asserted mid-frame aborts the frame immediately; no partial bytes are emitted after reset release.
REQ-033 Outputs follow reset asynchronously; after release, s_axis_tready follows enable from the next clock edge.

Verification
REQ-034 GEN basic: bytes 20,03 with m_axis_tready=1 -> output A5,03,00,01,02,03 (checksum 00^01^02=03); frame_count=1.
REQ-035 ECHO with backpressure: bytes 40,02,5A,C3 with m_axis_tready toggling 1/0 -> output A5,02,5A,C3,99, with no drops or duplicates.
REQ-036 Filtering and errors: bytes 00,FF,7E,20,01 -> err_count=1, then A5,01,00,00.
REQ-037 Length 256 and wrap: second GEN frame 20,00 after a prior frame of 3 bytes -> 256 payload bytes 03..FF,00,01,02 and checksum 00; frame_count=2.
REQ-038 Reset mid-frame: assert clk_core_res during PAYLOAD -> m_axis_tvalid=0 at once, busy=0, counters 0; a following 20,01 yields A5,01,00,00.
REQ-039 Saturation: 300 unknown command bytes -> err_count=FF.
